packet_verifier36: RTL and testbench
====================================

Name: packet_verifier36

Overview:
- Parametrised, multi-channel successor to the byte-serial packet verifier.
- Checks packets directly on the 36-bit FIFO interface at one word per cycle, with no 8-bit link-layer conversion.
- Tracks a sequence number per channel and checks length and XOR checksum.
- Sits at the sink end of loopback/BIST paths. Exposes saturating error counters to the settings/readback bus.

Parameters:
- NUM_CHAN, 4, number of channels with independent sequence tracking (1..16).
- CNT_WIDTH, 32, width of every statistics counter (8..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear: same effect as reset on all state and counters.
- data_i  in  36  FIFO word: [31:0] data, [32] SOF, [33] EOF, [35:34] occupancy.
- src_rdy_i  in  1  upstream word valid.
- dst_rdy_o  out  1  ready; a word is accepted when src_rdy_i and dst_rdy_o are both 1.
- total  out  CNT_WIDTH  packets terminated.
- crc_err  out  CNT_WIDTH  checksum mismatches.
- seq_err  out  CNT_WIDTH  sequence mismatches or illegal channel.
- len_err  out  CNT_WIDTH  length/framing errors.

Behaviour:
- Single clock. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset/clear:
  - All counters go to 0.
  - All per-channel valid bits go to 0.
  - FSM goes to IDLE.
  - dst_rdy_o is registered and goes to 0; it becomes 1 on the first cycle after reset/clear deasserts.
- Simultaneous clear and accept: clear wins and the word is discarded.
- Packet format:
  - Word 0 is the header: [31:28] chan, [27:16] len (total words including header and trailer), [15:0] seq.
  - Last word is the trailer: XOR of all preceding words' [31:0].
- FSM IDLE:
  - An accepted word without SOF is ignored (no counter change).
  - An accepted word with SOF and without EOF latches the header, sets csum = word[31:0] and wcnt = 1, then goes to BODY.
  - An accepted word with SOF and EOF is a 1-word packet: total+1 and len_err+1; no crc/seq check. Stay in IDLE.
- FSM BODY:
  - Each accepted non-EOF word: csum ^= word, wcnt+1.
  - wcnt saturates at 4095.
  - Accepted EOF word: terminate the packet (see below), then go to IDLE.
  - Accepted SOF word while in BODY (missing EOF): the old packet gets total+1 and len_err+1 only. The new word is then processed as an IDLE SOF in the same cycle.
- Termination at EOF (all checks are independent and may increment together):
  - total+1 always.
  - len_err+1 if (wcnt+1) != len, or occupancy != 0.
  - crc_err+1 if trailer != csum.
  - seq_err+1 if chan >= NUM_CHAN.
  - Otherwise, if valid[chan] is 1 and seq != exp[chan], seq_err+1.
  - For a legal chan, always set exp[chan] = seq+1 (mod 2^16, 0xFFFF wraps to 0x0000) and valid[chan] = 1.
  - The first packet on a channel after reset/clear never produces seq_err.
- Latency: counters reflect a packet on the cycle after its EOF word is accepted.
- Counters saturate at all-ones and never wrap.
- The header's sequence and channel checks are only applied at EOF; aborted packets do not update exp/valid.

Optional Feature:
- Macro: PACKET_VERIFIER36_BACKPRESSURE_EN.
- When defined:
  - A 16-bit LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset/clear) advances every cycle.
  - dst_rdy_o = 0 on cycles where LFSR[1:0] == 2'b00 (about 25% stall).
  - Used to exercise upstream backpressure; checking results are identical.
- When not defined: dst_rdy_o is constant 1 after reset, and there is no LFSR logic.

Test Plan:
- Good stream: chan 0, len 6, seq 0..9 with correct trailers -> total=10, all error counters 0.
- Sequence gap: chan 1 sends seq 5,6,8,9 -> seq_err=1, total=4. Channel 2 interleaved from seq 100 -> no extra seq_err.
- Length/framing: len field 6 but 5 words; next packet has occupancy 2 on EOF; then SOF before EOF -> len_err=3, total=3.
- Checksum: flip bit 0 of one payload word -> crc_err=1, len_err=0, seq_err=0.
- Illegal channel and wrap: chan 15 with NUM_CHAN=4 -> seq_err=1. chan 0 sends seq 0xFFFF then 0x0000 -> no seq_err.
- Saturation/clear: CNT_WIDTH=8, 300 bad-CRC packets -> crc_err=255, total=255. Pulse clear -> all counters 0 next cycle. Then resend seq 7 on chan 0 -> no seq_err.

Source files
------------

// File: rtl/packet_verifier36.sv
`default_nettype none
// ============================================================================
// Module   : packet_verifier36
// Brief    : 36-bit FIFO packet checker with per-channel sequence tracking,
//            length/checksum checks and saturating error counters.
//            Optional random stall: define PACKET_VERIFIER36_BACKPRESSURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module packet_verifier36 #(
    parameter int NUM_CHAN  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [35:0]          data_i,
    input  logic                 src_rdy_i,
    output logic                 dst_rdy_o,
    output logic [CNT_WIDTH-1:0] total,
    output logic [CNT_WIDTH-1:0] crc_err,
    output logic [CNT_WIDTH-1:0] seq_err,
    output logic [CNT_WIDTH-1:0] len_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic        rst_all;
    logic        rdy;
    logic        accept;
    logic [31:0] word;
    logic        sof, eof;
    logic [1:0]  occ;

    logic [3:0]  hdr_chan;
    logic [11:0] hdr_len;
    logic [15:0] hdr_seq;
    logic [31:0] csum;
    logic [11:0] wcnt;

    logic [NUM_CHAN-1:0] valid_q;
    logic [15:0]         exp_q [NUM_CHAN];

    logic        chan_legal;
    logic        valid_sel;
    logic [15:0] exp_sel;
    logic        len_bad, crc_bad, seq_bad;

    logic [1:0]  inc_total, inc_len;
    logic        inc_crc, inc_seq;
    logic        load_hdr, body_word, exp_upd;

    assign rst_all   = reset || clear;
    assign word      = data_i[31:0];
    assign sof       = data_i[32];
    assign eof       = data_i[33];
    assign occ       = data_i[35:34];
    assign dst_rdy_o = rdy;
    assign accept    = src_rdy_i && rdy && !clear;

`ifdef PACKET_VERIFIER36_BACKPRESSURE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr, lfsr_nxt;

    // Fibonacci form, taps 16/14/13/11
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk) begin
        if (rst_all) begin
            lfsr <= LFSR_SEED;
            rdy  <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            rdy  <= (lfsr_nxt[1:0] != 2'b00);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_all) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end
`endif

    always_comb begin
        valid_sel = 1'b0;
        exp_sel   = 16'h0000;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (hdr_chan == 4'(i)) begin
                valid_sel = valid_q[i];
                exp_sel   = exp_q[i];
            end
        end
    end

    assign chan_legal = ({1'b0, hdr_chan} < 5'(NUM_CHAN));
    // wcnt saturates at 4095, so wcnt+1 is evaluated in 13 bits to never alias a legal len
    assign len_bad    = (({1'b0, wcnt} + 13'd1) != {1'b0, hdr_len}) || (occ != 2'b00);
    assign crc_bad    = (word != csum);
    assign seq_bad    = !chan_legal || (valid_sel && (hdr_seq != exp_sel));

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        inc_total = 2'd0;
        inc_len   = 2'd0;
        inc_crc   = 1'b0;
        inc_seq   = 1'b0;
        load_hdr  = 1'b0;
        body_word = 1'b0;
        exp_upd   = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (sof && eof) begin
                        inc_total = 2'd1;
                        inc_len   = 2'd1;
                    end else if (sof) begin
                        load_hdr  = 1'b1;
                        state_nxt = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (sof) begin
                        // Abort the open packet, then treat the word as a fresh SOF
                        if (eof) begin
                            inc_total = 2'd2;
                            inc_len   = 2'd2;
                            state_nxt = ST_IDLE;
                        end else begin
                            inc_total = 2'd1;
                            inc_len   = 2'd1;
                            load_hdr  = 1'b1;
                        end
                    end else if (eof) begin
                        inc_total = 2'd1;
                        inc_len   = {1'b0, len_bad};
                        inc_crc   = crc_bad;
                        inc_seq   = seq_bad;
                        exp_upd   = chan_legal;
                        state_nxt = ST_IDLE;
                    end else begin
                        body_word = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst_all) begin
            hdr_chan <= 4'h0;
            hdr_len  <= 12'h000;
            hdr_seq  <= 16'h0000;
            csum     <= 32'h0;
            wcnt     <= 12'h000;
            valid_q  <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                exp_q[i] <= 16'h0000;
            end
            total    <= '0;
            crc_err  <= '0;
            seq_err  <= '0;
            len_err  <= '0;
        end else begin
            if (load_hdr) begin
                hdr_chan <= word[31:28];
                hdr_len  <= word[27:16];
                hdr_seq  <= word[15:0];
                csum     <= word;
                wcnt     <= 12'd1;
            end else if (body_word) begin
                csum <= csum ^ word;
                wcnt <= (wcnt == 12'hFFF) ? wcnt : wcnt + 12'd1;
            end
            if (exp_upd) begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                    if (hdr_chan == 4'(i)) begin
                        exp_q[i]   <= hdr_seq + 16'd1;
                        valid_q[i] <= 1'b1;
                    end
                end
            end
            total   <= sat_add(total, inc_total);
            len_err <= sat_add(len_err, inc_len);
            crc_err <= sat_add(crc_err, {1'b0, inc_crc});
            seq_err <= sat_add(seq_err, {1'b0, inc_seq});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_verifier36.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_verifier36
// Brief    : Directed, table-driven bench for packet_verifier36 (8-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_verifier36;

    localparam int NUM_CHAN  = 4;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clear = 1'b0;
    logic [35:0]          data_i = '0;
    logic                 src_rdy_i = 1'b0;
    logic                 dst_rdy_o;
    logic [CNT_WIDTH-1:0] total, crc_err, seq_err, len_err;

    int tests = 0;
    int fails = 0;

    packet_verifier36 #(.NUM_CHAN(NUM_CHAN), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .data_i    (data_i),
        .src_rdy_i (src_rdy_i),
        .dst_rdy_o (dst_rdy_o),
        .total     (total),
        .crc_err   (crc_err),
        .seq_err   (seq_err),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        logic [3:0]  chan;
        logic [11:0] lenf;
        logic [15:0] seq;
        int          nw;
        bit          bad;
        logic [1:0]  occ;
        bit          noeof;
        int          e_tot, e_crc, e_seq, e_len;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit clr, input logic [3:0] chan, input logic [11:0] lenf,
                       input logic [15:0] seq, input int nw, input bit bad,
                       input logic [1:0] occ, input bit noeof,
                       input int e_tot, input int e_crc, input int e_seq, input int e_len);
        vec_t v;
        v.clr = clr; v.chan = chan; v.lenf = lenf; v.seq = seq; v.nw = nw; v.bad = bad;
        v.occ = occ; v.noeof = noeof;
        v.e_tot = e_tot; v.e_crc = e_crc; v.e_seq = e_seq; v.e_len = e_len;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_counters(input string nm, input int idx,
                                input int t, input int c, input int s, input int l);
        chk({nm, ".total"},   idx, int'(total),   t);
        chk({nm, ".crc_err"}, idx, int'(crc_err), c);
        chk({nm, ".seq_err"}, idx, int'(seq_err), s);
        chk({nm, ".len_err"}, idx, int'(len_err), l);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_word(input logic [35:0] w);
        int n;
        data_i    = w;
        src_rdy_i = 1'b1;
        n = 0;
        while (!dst_rdy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got dst_rdy_o=0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [3:0] chan, input logic [11:0] lenf,
                            input logic [15:0] seq, input int nw, input bit bad,
                            input logic [1:0] occ, input bit noeof);
        logic [31:0] hdr, csum, pw;
        hdr  = {chan, lenf, seq};
        csum = hdr;
        send_word({2'b00, (nw == 1 && !noeof), 1'b1, hdr});
        for (int i = 1; i < nw - 1; i++) begin
            pw   = 32'h5A00_0000 ^ {12'h000, seq, 4'(i)};
            csum = csum ^ pw;
            send_word({2'b00, 1'b0, 1'b0, pw ^ {31'd0, (bad && i == 1)}});
        end
        if (nw >= 2) begin
            if (noeof) send_word({4'b0000, 32'hDEAD_0000});
            else       send_word({occ, 1'b1, 1'b0, csum});
        end
        src_rdy_i = 1'b0;
        data_i    = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Good stream, chan 0
        for (int i = 0; i < 10; i++)
            add(i == 0, 4'd0, 12'd6, 16'(i), 6, 0, 2'd0, 0, i + 1, 0, 0, 0);
        // Sequence gap on chan 1, chan 2 interleaved
        add(1, 4'd1, 12'd6, 16'd5,   6, 0, 2'd0, 0, 1, 0, 0, 0);
        add(0, 4'd2, 12'd6, 16'd100, 6, 0, 2'd0, 0, 2, 0, 0, 0);
        add(0, 4'd1, 12'd6, 16'd6,   6, 0, 2'd0, 0, 3, 0, 0, 0);
        add(0, 4'd2, 12'd6, 16'd101, 6, 0, 2'd0, 0, 4, 0, 0, 0);
        add(0, 4'd1, 12'd6, 16'd8,   6, 0, 2'd0, 0, 5, 0, 1, 0);
        add(0, 4'd2, 12'd6, 16'd102, 6, 0, 2'd0, 0, 6, 0, 1, 0);
        add(0, 4'd1, 12'd6, 16'd9,   6, 0, 2'd0, 0, 7, 0, 1, 0);
        // Length / framing: short, bad occupancy, missing EOF then restart
        add(1, 4'd0, 12'd6, 16'd0, 5, 0, 2'd0, 0, 1, 0, 0, 1);
        add(0, 4'd0, 12'd6, 16'd1, 6, 0, 2'd2, 0, 2, 0, 0, 2);
        add(0, 4'd0, 12'd6, 16'd2, 4, 0, 2'd0, 1, 2, 0, 0, 2);
        add(0, 4'd0, 12'd6, 16'd2, 6, 0, 2'd0, 0, 4, 0, 0, 3);
        // Checksum
        add(1, 4'd3, 12'd5, 16'd0, 5, 0, 2'd0, 0, 1, 0, 0, 0);
        add(0, 4'd3, 12'd5, 16'd1, 5, 1, 2'd0, 0, 2, 1, 0, 0);
        // Illegal channels, seq wrap, 1- and 2-word packets
        add(1, 4'd15, 12'd4, 16'd0,      4, 0, 2'd0, 0, 1, 0, 1, 0);
        add(0, 4'd0,  12'd4, 16'hFFFF,   4, 0, 2'd0, 0, 2, 0, 1, 0);
        add(0, 4'd0,  12'd4, 16'h0000,   4, 0, 2'd0, 0, 3, 0, 1, 0);
        add(0, 4'd0,  12'd4, 16'h0001,   4, 0, 2'd0, 0, 4, 0, 1, 0);
        add(0, 4'd4,  12'd4, 16'h0000,   4, 0, 2'd0, 0, 5, 0, 2, 0);
        add(0, 4'd1,  12'd1, 16'h0000,   1, 0, 2'd0, 0, 6, 0, 2, 1);
        add(0, 4'd1,  12'd2, 16'h0000,   2, 0, 2'd0, 0, 7, 0, 2, 1);
        // Open packet aborted by a 1-word packet: two terminations in one cycle
        add(1, 4'd2, 12'd6, 16'd0, 3, 0, 2'd0, 1, 0, 0, 0, 0);
        add(0, 4'd2, 12'd1, 16'd0, 1, 0, 2'd0, 0, 2, 0, 0, 2);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.dst_rdy", 0, int'(dst_rdy_o), 0);
        chk_counters("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.dst_rdy_after", 0, int'(dst_rdy_o), 1);

        foreach (vecs[k]) begin
            if (vecs[k].clr) do_clear();
            send_pkt(vecs[k].chan, vecs[k].lenf, vecs[k].seq, vecs[k].nw,
                     vecs[k].bad, vecs[k].occ, vecs[k].noeof);
            chk_counters("vec", k, vecs[k].e_tot, vecs[k].e_crc, vecs[k].e_seq, vecs[k].e_len);
        end

        // Saturation at 8 bits
        do_clear();
        for (int i = 0; i < 300; i++)
            send_pkt(4'd0, 12'd3, 16'(i), 3, 1, 2'd0, 0);
        chk_counters("sat", 0, 255, 255, 0, 0);

        // Clear wins over a simultaneously accepted 1-word packet
        clear     = 1'b1;
        data_i    = {2'b00, 1'b1, 1'b1, 4'd0, 12'd1, 16'd0};
        src_rdy_i = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        src_rdy_i = 1'b0;
        data_i    = '0;
        chk_counters("clear", 0, 0, 0, 0, 0);
        chk("clear.dst_rdy", 0, int'(dst_rdy_o), 0);
        @(negedge clk);
        chk("clear.dst_rdy_after", 0, int'(dst_rdy_o), 1);
        chk_counters("clear", 1, 0, 0, 0, 0);

        // Channel history forgotten after clear
        send_pkt(4'd0, 12'd6, 16'd7, 6, 0, 2'd0, 0);
        chk_counters("post_clear", 0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
